uart_tx_serializer: RTL

- 8N1 UART transmitter; the transmit-direction counterpart of the RX path in the UART_BCD top.
- Takes a byte over a valid/ready handshake and shifts it out on DataOut at a switch-selected baud rate: 9600, 57600 or 115200.
- Holds one byte in a holding register, so consecutive bytes go out back-to-back with no idle gap.
- Sits between the top-level byte source (RX loopback or switches, launched by the SendItem button logic) and the TX pin.

---
 rtl/uart_tx_serializer_pkg.sv | 25 ++
 rtl/uart_baud_tick.sv | 47 ++++
 rtl/uart_tx_serializer.sv | 135 +++++++++++++
 3 files changed

// File: rtl/uart_tx_serializer_pkg.sv
// Shared UART definitions: clock/baud divisors, baud-select codes and TX state encoding.
// The RX path uses the same divisors so both directions agree on bit timing.
package uart_tx_serializer_pkg;

  localparam int CLK_FREQ   = 50_000_000;
  // Integer division truncates to 5208 / 868 / 434 at 50 MHz.
  localparam int DIV_9600   = CLK_FREQ / 9600;
  localparam int DIV_57600  = CLK_FREQ / 57600;
  localparam int DIV_115200 = CLK_FREQ / 115200;

  localparam int BAUD_CNT_W     = 13;
  localparam int UART_DATA_BITS = 8;

  localparam logic [1:0] BAUD_9600   = 2'b00;
  localparam logic [1:0] BAUD_57600  = 2'b01;
  localparam logic [1:0] BAUD_115200 = 2'b10;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts 0..DIV-1 for the latched baud rate and flags the last
// cycle of each bit. Held at zero while restart is high.
module uart_baud_tick #(
  parameter int DIV_9600   = uart_tx_serializer_pkg::DIV_9600,
  parameter int DIV_57600  = uart_tx_serializer_pkg::DIV_57600,
  parameter int DIV_115200 = uart_tx_serializer_pkg::DIV_115200
) (
  input  logic       src_clk,
  input  logic       rst,
  input  logic       restart,
  input  logic [1:0] baud_sel_latched,
  output logic       bit_end
);
  import uart_tx_serializer_pkg::*;

  localparam logic [BAUD_CNT_W-1:0] LAST_9600   = BAUD_CNT_W'(DIV_9600 - 1);
  localparam logic [BAUD_CNT_W-1:0] LAST_57600  = BAUD_CNT_W'(DIV_57600 - 1);
  localparam logic [BAUD_CNT_W-1:0] LAST_115200 = BAUD_CNT_W'(DIV_115200 - 1);

  logic [BAUD_CNT_W-1:0] cnt_q, cnt_d;
  logic [BAUD_CNT_W-1:0] last_cnt;

  // bit_end depends only on the count, never on restart, so the FSM can use it
  // to decide a restart without forming a combinational loop.
  always_comb begin
    last_cnt = LAST_115200;
    case (baud_sel_latched)
      BAUD_9600:  last_cnt = LAST_9600;
      BAUD_57600: last_cnt = LAST_57600;
      default:    last_cnt = LAST_115200;
    endcase
    bit_end = (cnt_q == last_cnt);
    cnt_d   = cnt_q + BAUD_CNT_W'(1);
    if (restart || bit_end) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge src_clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// 8N1 UART transmitter with a one-byte holding register so queued bytes go out
// back-to-back. Baud rate is sampled at each start bit.
module uart_tx_serializer #(
  parameter int CLK_FREQ   = uart_tx_serializer_pkg::CLK_FREQ,
  parameter int DIV_9600   = CLK_FREQ / 9600,
  parameter int DIV_57600  = CLK_FREQ / 57600,
  parameter int DIV_115200 = CLK_FREQ / 115200
) (
  input  logic       src_clk,
  input  logic       rst,
  input  logic [1:0] baud_sel,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       frame_done,
  output logic       DataOut
);
  import uart_tx_serializer_pkg::*;

  tx_state_e                 state_q, state_d;
  logic [UART_DATA_BITS-1:0] hold_q, hold_d;
  logic                      hold_full_q, hold_full_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic [2:0]                bit_idx_q, bit_idx_d;
  logic [1:0]                baud_q, baud_d;
  logic                      data_out_q, data_out_d;

  logic bit_end;
  logic start_entry;
  logic accept;
  logic restart;

  assign accept     = tx_valid && !hold_full_q;
  assign restart    = (state_q == TX_IDLE) || start_entry;
  assign tx_ready   = !hold_full_q;
  assign tx_busy    = (state_q != TX_IDLE);
  assign frame_done = (state_q == TX_STOP) && bit_end;
  assign DataOut    = data_out_q;

  uart_baud_tick #(
    .DIV_9600   (DIV_9600),
    .DIV_57600  (DIV_57600),
    .DIV_115200 (DIV_115200)
  ) u_baud_tick (
    .src_clk          (src_clk),
    .rst              (rst),
    .restart          (restart),
    .baud_sel_latched (baud_q),
    .bit_end          (bit_end)
  );

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_idx_d   = bit_idx_q;
    baud_d      = baud_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    start_entry = 1'b0;

    case (state_q)
      TX_IDLE: begin
        if (hold_full_q) begin
          start_entry = 1'b1;
        end
      end
      TX_START: begin
        if (bit_end) begin
          state_d = TX_DATA;
        end
      end
      TX_DATA: begin
        if (bit_end) begin
          shift_d   = shift_q >> 1;
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'(UART_DATA_BITS - 1)) begin
            state_d = TX_STOP;
          end
        end
      end
      TX_STOP: begin
        if (bit_end) begin
          if (hold_full_q) begin
            start_entry = 1'b1;
          end else begin
            state_d = TX_IDLE;
          end
        end
      end
      default: state_d = TX_IDLE;
    endcase

    // Moving the held byte into the shifter frees the holding register; a byte
    // accepted in the same cycle refills it.
    if (start_entry) begin
      state_d     = TX_START;
      shift_d     = hold_q;
      bit_idx_d   = '0;
      baud_d      = baud_sel;
      hold_full_d = 1'b0;
    end
    if (accept) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
    end

    case (state_d)
      TX_START: data_out_d = 1'b0;
      TX_DATA:  data_out_d = shift_d[0];
      default:  data_out_d = 1'b1;
    endcase
  end

  always_ff @(posedge src_clk) begin
    if (rst) begin
      state_q     <= TX_IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      bit_idx_q   <= '0;
      baud_q      <= BAUD_9600;
      data_out_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      bit_idx_q   <= bit_idx_d;
      baud_q      <= baud_d;
      data_out_q  <= data_out_d;
    end
  end

endmodule
